// File: rtl/use_record_serializer.sv
// Drains per-element records in strict token order and emits them as AXI-Stream beats with tkeep/tlast.
// Defining USE_SER_RECORD_COUNT_EN adds a 32-bit recordCount output that counts completed records.
module use_record_serializer #(
  parameter int NUM_ELEMENTS           = 4,
  parameter int DATA_BUS_WIDTH_BYTES   = 8,
  parameter int MAX_UNCOMPRESSED_BYTES = 34,
  parameter int FIRST_ELEMENT_ID       = 0
) (
  input  logic                                               clk,
  input  logic                                               resetn,
  input  logic [NUM_ELEMENTS*MAX_UNCOMPRESSED_BYTES*8-1:0]   useStreamIn,
  input  logic [NUM_ELEMENTS*$clog2(MAX_UNCOMPRESSED_BYTES)-1:0] useLengthIn,
  output logic [NUM_ELEMENTS-1:0]                            useTaken,
  output logic [DATA_BUS_WIDTH_BYTES*8-1:0]                  m_axis_tdata,
  output logic [DATA_BUS_WIDTH_BYTES-1:0]                    m_axis_tkeep,
  output logic                                               m_axis_tvalid,
  input  logic                                               m_axis_tready,
  output logic                                               m_axis_tlast,
  output logic                                               lengthError
`ifdef USE_SER_RECORD_COUNT_EN
  ,
  output logic [31:0]                                        recordCount
`endif
);

  localparam int W         = DATA_BUS_WIDTH_BYTES;
  localparam int LW        = $clog2(MAX_UNCOMPRESSED_BYTES);
  localparam int REC_BITS  = MAX_UNCOMPRESSED_BYTES * 8;
  localparam int MAX_BEATS = (MAX_UNCOMPRESSED_BYTES + W - 1) / W;
  localparam int BUF_BYTES = MAX_BEATS * W;
  localparam int BW        = $clog2(MAX_BEATS + 1);
  localparam int PW        = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [BW-1:0]          beats_q, beats_d;
  logic [LW-1:0]          len_q, len_d;
  logic                   taken_q, taken_d;
  logic                   err_q, err_d;
  logic                   load;
  logic                   final_acc;
  logic [BUF_BYTES*8-1:0] buf_q;
  logic [BUF_BYTES*8-1:0] buf_in;

  logic [LW-1:0]          len_arr [NUM_ELEMENTS];
  logic [REC_BITS-1:0]    rec_arr [NUM_ELEMENTS];
  logic [W*8-1:0]         beat_words [MAX_BEATS];
  logic [LW-1:0]          len_sel;
  logic [REC_BITS-1:0]    rec_sel;
  logic [LW-1:0]          len_clamped;
  logic                   len_over;
  logic [BW-1:0]          beats_calc;
  logic                   last_beat;
  logic [31:0]            rem_w;
  logic [W*8-1:0]         beat_word;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ELEMENTS; gi++) begin : g_unpack
      assign len_arr[gi] = useLengthIn[gi*LW +: LW];
      assign rec_arr[gi] = useStreamIn[gi*REC_BITS +: REC_BITS];
      assign useTaken[gi] = taken_q && (ptr_q == PW'(gi));
    end
    // Buffer is padded to whole beats; padding bytes are never marked valid.
    for (gi = 0; gi < BUF_BYTES; gi++) begin : g_buf_in
      if (gi < MAX_UNCOMPRESSED_BYTES) begin : g_rec
        assign buf_in[gi*8 +: 8] = rec_sel[gi*8 +: 8];
      end else begin : g_pad
        assign buf_in[gi*8 +: 8] = 8'h00;
      end
    end
    for (gi = 0; gi < MAX_BEATS; gi++) begin : g_beats
      assign beat_words[gi] = buf_q[gi*W*8 +: W*8];
    end
    for (gi = 0; gi < W; gi++) begin : g_mask
      assign m_axis_tdata[gi*8 +: 8] = m_axis_tkeep[gi] ? beat_word[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  assign len_sel     = len_arr[ptr_q];
  assign rec_sel     = rec_arr[ptr_q];
  assign len_over    = (len_sel > LW'(MAX_UNCOMPRESSED_BYTES));
  assign len_clamped = len_over ? LW'(MAX_UNCOMPRESSED_BYTES) : len_sel;
  assign beats_calc  = BW'((32'(len_clamped) + 32'(W) - 32'd1) / 32'(W));
  assign last_beat   = (beat_q == beats_q - BW'(1));
  assign rem_w       = 32'(len_q) % 32'(W);
  assign beat_word   = beat_words[beat_q];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    beat_d    = beat_q;
    beats_d   = beats_q;
    len_d     = len_q;
    taken_d   = 1'b0;
    err_d     = err_q;
    load      = 1'b0;
    final_acc = 1'b0;
    case (state_q)
      IDLE: begin
        // Only the element under the pointer is ever considered.
        if (len_sel != '0) begin
          load    = 1'b1;
          taken_d = 1'b1;
          len_d   = len_clamped;
          beats_d = beats_calc;
          beat_d  = '0;
          err_d   = err_q | len_over;
          state_d = SEND;
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          if (last_beat) begin
            final_acc = 1'b1;
            state_d   = IDLE;
            ptr_d     = (ptr_q == PW'(NUM_ELEMENTS - 1)) ? '0 : ptr_q + PW'(1);
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ptr_q   <= PW'(FIRST_ELEMENT_ID);
      beat_q  <= '0;
      beats_q <= '0;
      len_q   <= '0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      beats_q <= beats_d;
      len_q   <= len_d;
      taken_q <= taken_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      buf_q <= buf_in;
    end
  end

  always_comb begin
    m_axis_tkeep = '0;
    if (state_q == SEND) begin
      if (!last_beat || rem_w == 32'd0) begin
        m_axis_tkeep = '1;
      end else begin
        m_axis_tkeep = ~({W{1'b1}} << rem_w);
      end
    end
  end

  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tlast  = (state_q == SEND) && last_beat;
  assign lengthError   = err_q;

`ifdef USE_SER_RECORD_COUNT_EN
  logic [31:0] rec_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rec_cnt_q <= '0;
    end else if (final_acc) begin
      rec_cnt_q <= rec_cnt_q + 32'd1;
    end
  end

  assign recordCount = rec_cnt_q;
`else
  logic unused_final_acc;
  assign unused_final_acc = final_acc;
`endif

endmodule

// File: tb/tb_use_record_serializer.sv
// Directed bench for use_record_serializer: scoreboard of expected beats, immediate-assertion checks.
module tb_use_record_serializer;

  localparam int NE   = 4;
  localparam int W    = 8;
  localparam int MAXB = 34;
  localparam int LW   = $clog2(MAXB);

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic [NE*MAXB*8-1:0] use_stream = '0;
  logic [NE*LW-1:0]     use_len = '0;
  logic [NE-1:0]        use_taken;
  logic [W*8-1:0]       tdata;
  logic [W-1:0]         tkeep;
  logic                 tvalid;
  logic                 tready = 1'b1;
  logic                 tlast;
  logic                 len_err;
`ifdef USE_SER_RECORD_COUNT_EN
  logic [31:0]          rec_cnt;
`endif

  int    checks = 0;
  int    failures = 0;
  int    hs_count = 0;
  int    exp_records = 0;
  int    lat;
  int    hs0;
  beat_t exp_q[$];
  beat_t mon_e;
  beat_t held;
  logic  prev_stall = 1'b0;
  logic  pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  use_record_serializer #(
    .NUM_ELEMENTS(NE),
    .DATA_BUS_WIDTH_BYTES(W),
    .MAX_UNCOMPRESSED_BYTES(MAXB),
    .FIRST_ELEMENT_ID(0)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .useStreamIn(use_stream),
    .useLengthIn(use_len),
    .useTaken(use_taken),
    .m_axis_tdata(tdata),
    .m_axis_tkeep(tkeep),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast(tlast),
    .lengthError(len_err)
`ifdef USE_SER_RECORD_COUNT_EN
    ,
    .recordCount(rec_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mbyte(input int e, input int i, input int seed);
    return 8'((seed * 13 + e * 64 + i * 3 + 1) & 255);
  endfunction

  task automatic set_record(input int e, input int len, input int seed);
    for (int i = 0; i < MAXB; i++) use_stream[(e*MAXB+i)*8 +: 8] = mbyte(e, i, seed);
    use_len[e*LW +: LW] = LW'(len);
  endtask

  task automatic clr_len(input int e);
    use_len[e*LW +: LW] = '0;
  endtask

  // Reference model: byte-by-byte placement, invalid lanes zero, clamp to buffer depth.
  task automatic push_expected(input int e, input int len, input int seed);
    int    eff;
    int    beats;
    beat_t b;
    eff   = (len > MAXB) ? MAXB : len;
    beats = (eff + W - 1) / W;
    for (int k = 0; k < beats; k++) begin
      b = '0;
      for (int j = 0; j < W; j++) begin
        if (k * W + j < eff) begin
          b.data[j*8 +: 8] = mbyte(e, k * W + j, seed);
          b.keep[j]        = 1'b1;
        end
      end
      b.last = (k == beats - 1);
      exp_q.push_back(b);
    end
    exp_records++;
  endtask

  task automatic wait_taken(input int e, input int max_cyc, output int lat_o);
    logic [NE-1:0] exp_t;
    exp_t    = '0;
    exp_t[e] = 1'b1;
    lat_o    = 0;
    for (int n = 1; n <= max_cyc; n++) begin
      @(negedge clk);
      if (use_taken != '0) begin
        lat_o = n;
        break;
      end
    end
    chk($sformatf("taken_e%0d", e), 64'(use_taken), 64'(exp_t));
    @(negedge clk);
    chk("taken_pulse_width", 64'(use_taken), 64'd0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tvalid) && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_idle"}, 64'(tvalid), 64'd0);
`ifdef USE_SER_RECORD_COUNT_EN
    chk({tag, "_record_count"}, 64'(rec_cnt), 64'(exp_records));
`endif
  endtask

  // Output monitor: pops the scoreboard on each handshake and checks stall stability.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(tvalid), 64'd1);
        chk("stall_data", tdata, held.data);
        chk("stall_keep", 64'(tkeep), 64'(held.keep));
        chk("stall_last", 64'(tlast), 64'(held.last));
      end
      if (tvalid && tready) begin
        hs_count++;
        $display("beat t=%0t data=%h keep=%h last=%b", $time, tdata, tkeep, tlast);
        chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("beat_data", tdata, mon_e.data);
          chk("beat_keep", 64'(tkeep), 64'(mon_e.keep));
          chk("beat_last", 64'(tlast), 64'(mon_e.last));
        end
      end
      prev_stall = tvalid && !tready;
      held       = {tdata, tkeep, tlast};
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    tready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tkeep", 64'(tkeep), 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_taken", 64'(use_taken), 64'd0);
    chk("rst_lenerr", 64'(len_err), 64'd0);
`ifdef USE_SER_RECORD_COUNT_EN
    chk("rst_reccnt", 64'(rec_cnt), 64'd0);
`endif
    @(posedge clk); #1 resetn = 1'b1;

    // Element 0, 23 bytes: 3 beats, last keep 0x7F, one-cycle latency.
    @(posedge clk); #1;
    set_record(0, 23, 1);
    push_expected(0, 23, 1);
    wait_taken(0, 4, lat);
    chk("first_beat_latency", 64'(lat), 64'd2);
    clr_len(0);
    drain("len23");

    // Element 1, 16 bytes: exact multiple of the bus width.
    set_record(1, 16, 2);
    push_expected(1, 16, 2);
    wait_taken(1, 20, lat);
    clr_len(1);
    drain("len16");

    // Element 2, 23 bytes under a stalling sink.
    @(posedge clk); #1 tready = 1'b0;
    set_record(2, 23, 3);
    push_expected(2, 23, 3);
    hs0 = hs_count;
    wait_taken(2, 20, lat);
    clr_len(2);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 tready = pat[i];
    end
    @(negedge clk);
    @(negedge clk);
    chk("stall_beats_accepted", 64'(hs_count - hs0), 64'd3);
    chk("stall_record_done", 64'(tvalid), 64'd0);
    @(posedge clk); #1 tready = 1'b1;
    drain("stall");

    set_record(3, 5, 4);
    push_expected(3, 5, 4);
    wait_taken(3, 20, lat);
    clr_len(3);
    drain("len5");

    // Full-depth records on all elements; order 0,1,2,3 then 0 again.
    for (int e = 0; e < NE; e++) begin
      set_record(e, 34, 10 + e);
      push_expected(e, 34, 10 + e);
    end
    wait_taken(0, 20, lat);
    set_record(0, 34, 14);
    push_expected(0, 34, 14);
    for (int e = 1; e < NE; e++) begin
      wait_taken(e, 20, lat);
      clr_len(e);
    end
    wait_taken(0, 20, lat);
    clr_len(0);
    drain("full_depth");

    set_record(1, 1, 5);
    push_expected(1, 1, 5);
    wait_taken(1, 20, lat);
    clr_len(1);
    drain("len1");

    set_record(2, 8, 6);
    push_expected(2, 8, 6);
    wait_taken(2, 20, lat);
    clr_len(2);
    drain("len8");
    chk("lenerr_before_overflow", 64'(len_err), 64'd0);

    // Oversized length is clamped to the buffer depth and flagged.
    set_record(3, 50, 7);
    push_expected(3, 50, 7);
    wait_taken(3, 20, lat);
    clr_len(3);
    drain("overflow");
    chk("lenerr_set", 64'(len_err), 64'd1);

    // Pointer at element 0 with no record; element 1 must wait.
    set_record(1, 12, 20);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("blocked_tvalid", 64'(tvalid), 64'd0);
      chk("blocked_taken", 64'(use_taken), 64'd0);
    end
    set_record(0, 9, 21);
    push_expected(0, 9, 21);
    push_expected(1, 12, 20);
    wait_taken(0, 20, lat);
    clr_len(0);
    wait_taken(1, 20, lat);
    clr_len(1);
    drain("in_order");
    chk("lenerr_sticky", 64'(len_err), 64'd1);

    // Reset in the middle of a 3-beat record on element 2.
    @(posedge clk); #1 tready = 1'b0;
    set_record(2, 23, 22);
    push_expected(2, 23, 22);
    wait_taken(2, 20, lat);
    clr_len(2);
    @(posedge clk); #1 tready = 1'b1;
    @(posedge clk); #1 tready = 1'b0;
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(tvalid), 64'd0);
    chk("midrst_tlast", 64'(tlast), 64'd0);
    chk("midrst_tkeep", 64'(tkeep), 64'd0);
    chk("midrst_tdata", tdata, 64'd0);
    chk("midrst_lenerr", 64'(len_err), 64'd0);
    exp_q.delete();
    exp_records = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    resetn = 1'b1;
    tready = 1'b1;
    set_record(0, 7, 23);
    set_record(1, 17, 24);
    push_expected(0, 7, 23);
    push_expected(1, 17, 24);
    wait_taken(0, 20, lat);
    clr_len(0);
    wait_taken(1, 20, lat);
    clr_len(1);
    drain("after_reset");
    chk("lenerr_after_reset", 64'(len_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
